decrypt_iterative: RTL

- Iterative AES-128 decryption engine: the inverse counterpart of the encrypt round datapath.
- Accepts one 128-bit ciphertext plus 128-bit cipher key over a valid/ready handshake.
- Runs one inverse round per clock on a single shared round datapath, deriving round keys on the fly (forward expansion to rk10, then inverse expansion down to rk0).
- Returns plaintext over a valid/ready handshake; sits beside the encrypt path in the AES128 top level.

---
 rtl/aes_pkg.sv | 128 ++++++++++++
 rtl/InvSubWord.sv | 13 +
 rtl/SubWord.sv | 13 +
 rtl/decrypt_iterative.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the iterative AES-128 decrypt engine.
//   - FSM state type for decrypt_iterative
//   - rcon table lookup
//   - GF(2^8) helpers (mod x^8+x^4+x^3+x+1), forward/inverse S-box functions
//   - RotWord, InvShiftRows, InvMixColumns on 128-bit FIPS-197 ordered blocks
//     (bits [127:120] = state byte 0, byte index = row + 4*column)
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    INIT,
    ROUND,
    FINAL,
    DONE
  } state_e;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 = prod a^(2^k), k=1..7; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Row r is rotated right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned row = 0; row < 4; row++) begin
        r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+4-row)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
      r[119-32*c -: 8] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
      r[111-32*c -: 8] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
      r[103-32*c -: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/InvSubWord.sv
// InvSubWord: inverse AES S-box on one byte (instanced 16x for InvSubBytes).
//   a_i  input  [7:0]  byte in
//   y_o  output [7:0]  InvS-box(a_i)
module InvSubWord
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = sbox_inv(a_i);

endmodule

// File: rtl/SubWord.sv
// SubWord: forward AES S-box on one byte (used four-wide by the key schedule).
//   a_i  input  [7:0]  byte in
//   y_o  output [7:0]  S-box(a_i)
module SubWord
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = sbox_fwd(a_i);

endmodule

// File: rtl/decrypt_iterative.sv
// decrypt_iterative: iterative AES-128 decryption, one inverse round per clock.
// Round keys are derived on the fly: forward expansion up to rk10, then inverse
// expansion back down to rk0 while the rounds run.
//   CLK         input         clock, rising edge
//   RST_N       input         asynchronous active-low reset
//   in_valid    input         inputData/inputKey valid
//   in_ready    output        high only in IDLE
//   inputData   input  [127:0] ciphertext, [127:120] = state byte 0
//   inputKey    input  [127:0] cipher key, same byte order
//   out_valid   output        outputData holds plaintext
//   out_ready   input         consumer accepts outputData
//   outputData  output [127:0] plaintext (holds last value)
//   busy        output        high in any state other than IDLE
// Optional macro AES_KEY_CACHE_EN: caches the last key and its rk10 so a job
// with a repeated key skips KEYEXP (11-cycle latency instead of 21).
module decrypt_iterative
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] inputData,
  input  logic [127:0] inputKey,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] outputData,
  output logic         busy
);

  if (NR != 10) begin : g_bad_nr
    $error("decrypt_iterative: NR must be 10 for AES-128");
  end

  state_e       fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] out_q, out_d;
  logic         ov_q, ov_d;

`ifdef AES_KEY_CACHE_EN
  logic [127:0] last_key_q, last_key_d;
  logic [127:0] last_rk10_q, last_rk10_d;
  logic         cache_valid_q, cache_valid_d;
`endif

  // Key schedule: one shared SubWord datapath for forward and inverse steps.
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sw_in, sw_out, rc_word;
  logic [127:0] fwd_rk, inv_rk;

  assign w0 = rk_q[127:96];
  assign w1 = rk_q[95:64];
  assign w2 = rk_q[63:32];
  assign w3 = rk_q[31:0];
  assign rc_word = {rcon(rnd_q), 24'h000000};
  assign sw_in = rot_word((fsm_q == KEYEXP) ? w3 : (w3 ^ w2));

  for (genvar g = 0; g < 4; g++) begin : g_sw
    SubWord u_sw (
      .a_i(sw_in[8*g +: 8]),
      .y_o(sw_out[8*g +: 8])
    );
  end

  always_comb begin
    logic [31:0] f0, f1, f2;
    f0 = w0 ^ sw_out ^ rc_word;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    fwd_rk = {f0, f1, f2, w3 ^ f2};
    inv_rk = {w0 ^ sw_out ^ rc_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  end

  // Round datapath: InvShiftRows -> InvSubBytes, then AddRoundKey (+InvMixColumns).
  logic [127:0] isr_out, isb_out, round_out, final_out;

  assign isr_out = inv_shift_rows(state_q);

  for (genvar g = 0; g < 16; g++) begin : g_isb
    InvSubWord u_isb (
      .a_i(isr_out[8*g +: 8]),
      .y_o(isb_out[8*g +: 8])
    );
  end

  assign final_out = isb_out ^ rk_q;
  assign round_out = inv_mix_columns(final_out);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    out_d   = out_q;
    ov_d    = ov_q;
`ifdef AES_KEY_CACHE_EN
    last_key_d    = last_key_q;
    last_rk10_d   = last_rk10_q;
    cache_valid_d = cache_valid_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = inputData;
          rk_d    = inputKey;
          rnd_d   = 4'd1;
          fsm_d   = KEYEXP;
`ifdef AES_KEY_CACHE_EN
          // On a miss the cache is invalidated and the key captured now, so
          // a reset during KEYEXP can never leave a stale key/rk10 pairing.
          if (cache_valid_q && (inputKey == last_key_q)) begin
            rk_d  = last_rk10_q;
            rnd_d = 4'd10;
            fsm_d = INIT;
          end else begin
            last_key_d    = inputKey;
            cache_valid_d = 1'b0;
          end
`endif
        end
      end
      KEYEXP: begin
        rk_d = fwd_rk;
        if (rnd_q == 4'd10) begin
          // rnd stays at 10 so INIT picks up rcon[10] for the first inverse step.
          fsm_d = INIT;
`ifdef AES_KEY_CACHE_EN
          last_rk10_d   = fwd_rk;
          cache_valid_d = 1'b1;
`endif
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      INIT: begin
        state_d = state_q ^ rk_q;
        rk_d    = inv_rk;
        rnd_d   = 4'd9;
        fsm_d   = ROUND;
      end
      ROUND: begin
        state_d = round_out;
        rk_d    = inv_rk;
        rnd_d   = rnd_q - 4'd1;
        if (rnd_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        state_d = final_out;
        out_d   = final_out;
        ov_d    = 1'b1;
        fsm_d   = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ov_d  = 1'b0;
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
`ifdef AES_KEY_CACHE_EN
      last_key_q    <= '0;
      last_rk10_q   <= '0;
      cache_valid_q <= 1'b0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
`ifdef AES_KEY_CACHE_EN
      last_key_q    <= last_key_d;
      last_rk10_q   <= last_rk10_d;
      cache_valid_q <= cache_valid_d;
`endif
    end
  end

  assign in_ready   = (fsm_q == IDLE);
  assign busy       = (fsm_q != IDLE);
  assign out_valid  = ov_q;
  assign outputData = out_q;

endmodule
